fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch sequencer directly upstream of program_memory.
- Owns the PC and drives program_memory's 4-bit program_counter input.
- Consumes the registered 21-bit instruction that program_memory returns one cycle later, and presents it to the decoder with a valid/stall handshake.
- Handles branch redirects from execute, back-pressure replay, HALT detection and a retired-instruction count.

Parameters:
- ADDR_W, 4, program address width; 16 entries, wraps modulo 2^ADDR_W.
- INSTR_W, 21, instruction width; opcode = instr[INSTR_W-1 -: 4].
- HALT_OPCODE, 4'b1111, opcode that stops fetch once accepted.
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; leaves IDLE.
- stall  input  1  decoder cannot accept the current instruction.
- branch_taken  input  1  execute redirects fetch this cycle.
- branch_target  input  ADDR_W  redirect address.
- instruction  input  INSTR_W  registered read data from program_memory.
- program_counter  output  ADDR_W  read address to program_memory; combinational mux, see below.
- instr_out  output  INSTR_W  equals instruction (pass-through).
- instr_pc  output  ADDR_W  address of instr_out.
- instr_valid  output  1  instr_out is a live, correct-path instruction.
- halted  output  1  high in HALTED state.
- instr_count  output  CNT_W  number of accepted instructions, saturating.

Behaviour:
- State registers:
  - state: IDLE / RUN / HALTED.
  - pc_q: next address to fetch.
  - fetch_pc_q: address whose data is on instruction this cycle.
  - vld_q: that data is live.
  - cnt_q: retired-instruction count.
- Reset (reset=1 at posedge), from any state including mid-run:
  - state=IDLE, pc_q=0, fetch_pc_q=0, vld_q=0, cnt_q=0.
  - Outputs: instr_valid=0, halted=0, instr_count=0, program_counter=0.
  - reset has priority over all other inputs.
- Derived signals:
  - accept = instr_valid & ~stall.
  - instr_valid = vld_q & (state==RUN) & ~branch_taken. The wrong-path instruction is squashed in the same cycle as the redirect.
- program_counter mux, priority order:
  1. branch_taken & RUN: branch_target.
  2. stall & vld_q & RUN: fetch_pc_q (replay, so memory re-reads the held instruction).
  3. Otherwise: pc_q.
- IDLE:
  - program_counter=pc_q=0; vld_q stays 0.
  - start=1 moves to RUN. The first fetch (address 0) occurs at the edge that leaves IDLE only if start is registered.
  - The first valid instruction appears 2 cycles after the start pulse.
- RUN, every posedge:
  - fetch_pc_q <= program_counter.
  - vld_q <= 1.
  - pc_q <= program_counter + 1, which wraps 15 -> 0.
  - Fetch latency is 1 cycle from address to instr_valid.
- Stall: pc_q holds its value (program_counter = fetch_pc_q, so pc_q <= fetch_pc_q+1, unchanged). instr_out and instr_pc remain stable while stall is high.
- Branch wins over stall and over HALT:
  - The squashed instruction is not counted and does not halt.
  - The next cycle shows instr_pc=branch_target with instr_valid=1 (unless stalled).
- HALT: when accept=1 and opcode==HALT_OPCODE:
  - state <= HALTED, vld_q <= 0.
  - The HALT itself is counted.
- HALTED:
  - instr_valid=0, halted=1.
  - program_counter = pc_q, frozen.
  - Exit only by reset; start is ignored.
- instr_count: cnt_q increments on each accept and saturates at 2^CNT_W-1 with no wrap.
- start asserted while in RUN has no effect.

Decomposition:
- Shared package fetch_pkg holds:
  - ADDR_W, INSTR_W, CNT_W.
  - HALT_OPCODE and the opcode field slice constants (OPC_MSB=20, OPC_LSB=17).
  - The state enum (IDLE, RUN, HALTED).
- The decoder reuses the opcode constants from fetch_pkg.
- No sub-module; one flat module.
- The bench instantiates fetch_unit together with program_memory.

Test Plan:
- Reset, start at cycle 2, no stall, memory addresses 0..4 preloaded:
  - instr_valid rises at cycle 4.
  - instr_pc steps 0,1,2,3,4 on consecutive cycles.
  - instr_out[20:17] = 1000, 1000, 0000, 1010, 1001.
- Stall held 3 cycles while instr_pc=2:
  - program_counter=2 throughout the stall.
  - instr_out stays 000000101001100000000.
  - instr_pc=3 appears the cycle after stall drops.
  - instr_count is unchanged during the stall.
- branch_taken=1, branch_target=4'd1 while instr_pc=3:
  - instr_valid=0 that cycle.
  - Next cycle instr_pc=1, then 2.
  - The squashed address-3 instruction is not counted.
- Run from address 13 with no branches:
  - instr_pc sequence 13, 14, 15, 0, 1 (wrap-around).
- HALT (opcode 1111) at address 5:
  - Accepted HALT drives halted=1 the next cycle, with instr_valid=0 thereafter.
  - instr_count=6.
  - start pulse is ignored; reset returns to IDLE with instr_count=0.
- reset asserted mid-stall with a pending branch:
  - Next cycle: state IDLE, program_counter=0, instr_valid=0, instr_count=0.
- CNT_W=2 override: the fourth and later accepts hold instr_count=3 (saturation).

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the fetch sequencer and its
// consumers (decoder reuses the opcode slice constants).
package fetch_pkg;
    localparam int ADDR_W  = 4;
    localparam int INSTR_W = 21;
    localparam int CNT_W   = 8;

    localparam int OPC_MSB = 20;
    localparam int OPC_LSB = 17;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_W-1:0] HALT_OPCODE = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_t;
endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, pairs program_memory's registered
// read data with its address, and handles redirect, replay, HALT and counting.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               ADDR_W      = fetch_pkg::ADDR_W,
    parameter int               INSTR_W     = fetch_pkg::INSTR_W,
    parameter int               CNT_W       = fetch_pkg::CNT_W,
    parameter logic [OPC_W-1:0] HALT_OPCODE = fetch_pkg::HALT_OPCODE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  program_counter,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic               halted,
    output logic [CNT_W-1:0]   instr_count
);

    state_t             state;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  fetch_pc_q;
    logic               vld_q;
    logic [CNT_W-1:0]   cnt_q;

    logic run;
    logic accept;
    logic is_halt;

    assign run     = (state == RUN);
    assign is_halt = (instruction[INSTR_W-1 -: OPC_W] == HALT_OPCODE);

    // A redirect squashes the wrong-path instruction in the same cycle.
    assign instr_valid = vld_q & run & ~branch_taken;
    assign accept      = instr_valid & ~stall;

    // Replay re-reads the held address so memory keeps presenting the same word.
    always_comb begin
        program_counter = pc_q;
        if (branch_taken && run)
            program_counter = branch_target;
        else if (stall && vld_q && run)
            program_counter = fetch_pc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc_q       <= '0;
            fetch_pc_q <= '0;
            vld_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start)
                        state <= RUN;
                end
                RUN: begin
                    fetch_pc_q <= program_counter;
                    pc_q       <= program_counter + ADDR_W'(1);
                    vld_q      <= 1'b1;
                    if (accept && cnt_q != '1)
                        cnt_q <= cnt_q + CNT_W'(1);
                    if (accept && is_halt) begin
                        state <= HALTED;
                        vld_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign instr_out   = instruction;
    assign instr_pc    = fetch_pc_q;
    assign halted      = (state == HALTED);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench: fetch_unit paired with a registered program memory model,
// plus a CNT_W=2 copy driven identically to observe counter saturation.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset, start, stall, branch_taken;
    logic [3:0]  branch_target;
    logic [3:0]  program_counter, instr_pc, pc2, ipc2;
    logic [20:0] instruction, instr_out, instr2, iout2;
    logic        instr_valid, halted, v2, h2;
    logic [7:0]  instr_count;
    logic [1:0]  cnt2;
    logic [20:0] mem [16];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        instruction <= mem[program_counter];
        instr2      <= mem[pc2];
    end

    fetch_unit dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instruction(instruction), .program_counter(program_counter),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .halted(halted), .instr_count(instr_count)
    );

    fetch_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instruction(instr2), .program_counter(pc2),
        .instr_out(iout2), .instr_pc(ipc2), .instr_valid(v2),
        .halted(h2), .instr_count(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [3:0] opc_exp [6];
    logic [3:0] wrap_seq [5];

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 4'd0;
        for (int i = 0; i < 16; i++) mem[i] = {4'b0001, 17'(i)};
        mem[0] = {4'b1000, 17'h00011};
        mem[1] = {4'b1000, 17'h00022};
        mem[2] = 21'b000000101001100000000;
        mem[3] = {4'b1010, 17'h00033};
        mem[4] = {4'b1001, 17'h00044};
        mem[5] = {4'b1111, 17'h00000};
        opc_exp[0] = 4'b1000; opc_exp[1] = 4'b1000; opc_exp[2] = 4'b0000;
        opc_exp[3] = 4'b1010; opc_exp[4] = 4'b1001; opc_exp[5] = 4'b1111;
        wrap_seq[0] = 4'd13; wrap_seq[1] = 4'd14; wrap_seq[2] = 4'd15;
        wrap_seq[3] = 4'd0;  wrap_seq[4] = 4'd1;

        // Reset state
        cyc(); cyc();
        chk("rst_pc", program_counter, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_count", instr_count, 0);
        reset = 1'b0;
        cyc();
        #1 chk("idle_valid", instr_valid, 0);

        // Straight run 0..5 ending in HALT
        start = 1'b1;
        cyc();
        start = 1'b0;
        #1;
        chk("run_first_pc", program_counter, 0);
        chk("run_first_valid", instr_valid, 0);
        for (int k = 0; k < 6; k++) begin
            cyc();
            #1;
            chk("seq_valid", instr_valid, 1);
            chk("seq_pc", instr_pc, k);
            chk("seq_opc", instr_out[20:17], opc_exp[k]);
            chk("seq_count", instr_count, k);
            chk("sat_count", cnt2, (k > 3) ? 3 : k);
        end
        cyc();
        #1;
        chk("halt_halted", halted, 1);
        chk("halt_valid", instr_valid, 0);
        chk("halt_count", instr_count, 6);
        chk("halt_sat", cnt2, 3);
        chk("halt_pc", program_counter, 7);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        #1;
        chk("halt_start_ign", halted, 1);
        chk("halt_valid2", instr_valid, 0);
        chk("halt_pc_frozen", program_counter, 7);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        chk("hrst_halted", halted, 0);
        chk("hrst_count", instr_count, 0);
        chk("hrst_valid", instr_valid, 0);

        // Stall, branch and wrap scenario
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc(); cyc();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_pc", program_counter, 2);
            chk("stall_ipc", instr_pc, 2);
            chk("stall_out", instr_out, 21'b000000101001100000000);
            chk("stall_count", instr_count, 2);
            cyc();
        end
        stall = 1'b0;
        #1;
        chk("unstall_valid", instr_valid, 1);
        chk("unstall_pc", program_counter, 3);
        cyc();
        #1;
        chk("post_stall_ipc", instr_pc, 3);
        chk("post_stall_count", instr_count, 3);
        branch_taken = 1'b1; branch_target = 4'd1;
        #1;
        chk("br_squash", instr_valid, 0);
        chk("br_pc", program_counter, 1);
        cyc();
        branch_taken = 1'b0;
        #1;
        chk("br_ipc1", instr_pc, 1);
        chk("br_valid", instr_valid, 1);
        chk("br_nocount", instr_count, 3);
        cyc();
        #1;
        chk("br_ipc2", instr_pc, 2);
        chk("br_count2", instr_count, 4);
        branch_taken = 1'b1; branch_target = 4'd13;
        cyc();
        branch_taken = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("wrap_ipc", instr_pc, wrap_seq[i]);
            chk("wrap_count", instr_count, 4 + i);
            cyc();
        end

        // Reset mid-stall with a pending branch
        stall = 1'b1;
        cyc();
        branch_taken = 1'b1; branch_target = 4'd9; reset = 1'b1;
        cyc();
        reset = 1'b0; branch_taken = 1'b0; stall = 1'b0;
        #1;
        chk("mrst_pc", program_counter, 0);
        chk("mrst_valid", instr_valid, 0);
        chk("mrst_count", instr_count, 0);
        chk("mrst_halted", halted, 0);
        cyc();
        #1 chk("mrst_idle", instr_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
